// File: rtl/masker_pkg.sv
// Shared widths, S1 payload layout and the rotate helper for the masker pipeline.
package masker_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic [DATA_W-1:0] rotated;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] a;
  } s1_payload_t;

  // Upper half of the doubled word shifted left is the left rotation.
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                             input logic [SHAMT_W-1:0] n);
    logic [2*DATA_W-1:0] dbl;
    dbl = {x, x} << n;
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/masker_mask_gen.sv
// Field mask generator: bit i set iff mskr <= i <= mskl (empty when mskr > mskl).
module mask_gen
  import masker_pkg::*;
(
  input  logic [SHAMT_W-1:0] mskl,
  input  logic [SHAMT_W-1:0] mskr,
  output logic [DATA_W-1:0]  mask
);

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    localparam logic [SHAMT_W-1:0] BIT_IDX = SHAMT_W'(gi);
    assign mask[gi] = (BIT_IDX >= mskr) && (BIT_IDX <= mskl);
  end

endmodule

// File: rtl/masker_pipe.sv
// Two-stage rotate-and-mask merge pipeline with valid/ready handshakes and flush.
// Optional delivered-result counter on op_count when MASKER_PERF_COUNT_EN is defined.
module masker_pipe
  import masker_pkg::*;
#(
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       m,
  input  logic [W-1:0]       a,
  input  logic [SHAMT_W-1:0] rot,
  input  logic [SHAMT_W-1:0] mskl,
  input  logic [SHAMT_W-1:0] mskr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       r
`ifdef MASKER_PERF_COUNT_EN
  ,
  output logic [15:0]        op_count
`endif
);

  logic              s1_valid_reg;
  s1_payload_t       s1_data_reg;
  logic              s2_valid_reg;
  logic [W-1:0]      r_reg;

  logic [DATA_W-1:0] mask_next;
  s1_payload_t       payload_next;
  logic [W-1:0]      merged_next;
  logic              s2_load;
  logic              s1_advance;
  logic              accept;

  mask_gen u_mask_gen (
    .mskl (mskl),
    .mskr (mskr),
    .mask (mask_next)
  );

  assign payload_next.rotated = rotl(m, rot);
  assign payload_next.mask    = mask_next;
  assign payload_next.a       = a;

  assign merged_next = (s1_data_reg.rotated & s1_data_reg.mask) |
                       (s1_data_reg.a & ~s1_data_reg.mask);

  // S1 moves forward exactly when S2 can take its contents.
  assign s2_load    = !s2_valid_reg || out_ready;
  assign s1_advance = s2_load;
  assign in_ready   = (!s1_valid_reg || s1_advance) && !flush;
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s2_valid_reg <= 1'b0;
      r_reg        <= '0;
    end else if (flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          r_reg <= merged_next;
        end
      end
      if (!s1_valid_reg || s1_advance) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_data_reg <= payload_next;
        end
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign r         = r_reg;

`ifdef MASKER_PERF_COUNT_EN
  logic [15:0] op_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count_reg <= '0;
    end else if (s2_valid_reg && out_ready) begin
      op_count_reg <= op_count_reg + 16'd1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_masker_pipe.sv
// Directed self-checking bench for masker_pipe; op_count checks need MASKER_PERF_COUNT_EN.
module tb_masker_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] m;
  logic [31:0] a;
  logic [4:0]  rot;
  logic [4:0]  mskl;
  logic [4:0]  mskr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
`ifdef MASKER_PERF_COUNT_EN
  logic [15:0] op_count;
`endif

  int tests = 0;
  int fails = 0;

  masker_pipe #(.W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m         (m),
    .a         (a),
    .rot       (rot),
    .mskl      (mskl),
    .mskr      (mskr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r)
`ifdef MASKER_PERF_COUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] mv, input logic [31:0] av, input logic [4:0] rv,
                       input logic [4:0] lv, input logic [4:0] rrv);
    m = mv; a = av; rot = rv; mskl = lv; mskr = rrv;
  endtask

  // Single request with out_ready high: result must appear exactly two edges after acceptance.
  task automatic run_single(input string tag, input logic [31:0] mv, input logic [31:0] av,
                            input logic [4:0] rv, input logic [4:0] lv, input logic [4:0] rrv,
                            input logic [31:0] exp);
    step();
    drive(mv, av, rv, lv, rrv);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    check({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    step();
    check({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_r"}, r, exp);
  endtask

`ifdef MASKER_PERF_COUNT_EN
  int exp_ops = 0;

  // Stream until the bench has seen `target` transfers, then park with out_ready low.
  task automatic run_transfers(input int target, input logic [15:0] exp_cnt, input string tag);
    int  cyc;
    logic xfer;
    cyc = 0;
    while (exp_ops < target && cyc < 70000) begin
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      xfer = out_valid;
      step();
      if (xfer) exp_ops++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check({tag, "_budget"}, exp_ops, target);
    check({tag, "_op_count"}, {16'd0, op_count}, {16'd0, exp_cnt});
  endtask
`endif

  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

    // Reset state
    step(); step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_r", r, 32'h0000_0000);
`ifdef MASKER_PERF_COUNT_EN
    check("rst_op_count", {16'd0, op_count}, 32'd0);
`endif
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Function and boundary cases
    run_single("basic",     32'h0000_00FF, 32'hFFFF_0000, 5'd8,  5'd15, 5'd8,  32'hFFFF_FF00);
    run_single("empty",     32'hFFFF_FFFF, 32'h1234_5678, 5'd0,  5'd3,  5'd5,  32'h1234_5678);
    run_single("wrap",      32'h0000_0001, 32'h0000_0000, 5'd31, 5'd31, 5'd0,  32'h8000_0000);
    run_single("full_rot4", 32'h1234_5678, 32'h0000_0000, 5'd4,  5'd31, 5'd0,  32'h2345_6781);
    run_single("bit0",      32'h0000_0000, 32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFE);
    run_single("bit31",     32'h8000_0000, 32'h0000_0000, 5'd0,  5'd31, 5'd31, 32'h8000_0000);

    // Backpressure: three back-to-back requests with out_ready low for four cycles
    step();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(32'h0000_00AB, 32'h0, 5'd0, 5'd7, 5'd0);
    #1;
    check("bp_acc_a", {31'd0, in_ready}, 32'd1);
    step();
    drive(32'h0000_00CD, 32'h0, 5'd8, 5'd15, 5'd8);
    #1;
    check("bp_acc_b", {31'd0, in_ready}, 32'd1);
    step();
    drive(32'h0000_00EF, 32'h1111_1111, 5'd16, 5'd23, 5'd16);
    #1;
    check("bp_stall1_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_stall1_valid", {31'd0, out_valid}, 32'd1);
    check("bp_stall1_r", r, 32'h0000_00AB);
    step();
    check("bp_stall2_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_stall2_r", r, 32'h0000_00AB);
    step();
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_res_a", r, 32'h0000_00AB);
    step();
    in_valid = 1'b0;
    #1;
    check("bp_res_b_valid", {31'd0, out_valid}, 32'd1);
    check("bp_res_b", r, 32'h0000_CD00);
    step();
    check("bp_res_c_valid", {31'd0, out_valid}, 32'd1);
    check("bp_res_c", r, 32'h11EF_1111);
    step();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-stream drops in-flight work
    out_ready = 1'b0; in_valid = 1'b1;
    drive(32'h0000_0055, 32'h0, 5'd0, 5'd7, 5'd0);
    step(); step();
    in_valid = 1'b0;
    #1;
    check("rstmid_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_r", r, 32'h0000_0000);
    step();
    reset = 1'b0; out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("rstmid_no_stale", seen, 32'd0);

    // Flush with two requests in flight (no transfers: out_ready low)
    out_ready = 1'b0; in_valid = 1'b1;
    drive(32'h0000_0011, 32'h0, 5'd0, 5'd7, 5'd0);
    step();
    drive(32'h0000_0022, 32'h0, 5'd0, 5'd7, 5'd0);
    step();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    step();
    flush = 1'b0;
    #1;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
`ifdef MASKER_PERF_COUNT_EN
    check("flush_op_count", {16'd0, op_count}, 32'd0);
`endif
    // Flush blocks acceptance even on an empty, ready pipeline
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
    #1;
    check("flush_block_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_block_no_result", {31'd0, out_valid}, 32'd0);
    run_single("post_flush", 32'h0000_000F, 32'hF000_0000, 5'd4, 5'd7, 5'd4, 32'hF000_00F0);

`ifdef MASKER_PERF_COUNT_EN
    // Counter wrap
    reset = 1'b1;
    step();
    check("cnt_reset", {16'd0, op_count}, 32'd0);
    reset = 1'b0;
    drive(32'h0000_0001, 32'h0, 5'd0, 5'd0, 5'd0);
    exp_ops = 0;
    run_transfers(65535, 16'hFFFF, "cnt_ffff");
    run_transfers(65536, 16'h0000, "cnt_wrap");
    run_transfers(65537, 16'h0001, "cnt_one");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
